// File: rtl/mmu_tlb_miss_sched.sv
// mmu_tlb_miss_sched: serialises L1 ITLB/DTLB misses onto the shared-TLB lookup
// port and the page-table walker, refilling the shared TLB from good walks and
// returning the PTE to the L1 TLB that missed. One miss is in flight at a time.
// Optional build macro MMU_SCHED_PERF_EN adds hit/walk performance counters.
module mmu_tlb_miss_sched #(
    parameter int VPN_W      = 27,
    parameter int ASID_W     = 16,
    parameter int PTE_W      = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [ASID_W-1:0] asid_i,
    input  logic              itlb_req_i,
    input  logic [VPN_W-1:0]  itlb_vpn_i,
    output logic              itlb_gnt_o,
    output logic              itlb_rsp_o,
    input  logic              dtlb_req_i,
    input  logic [VPN_W-1:0]  dtlb_vpn_i,
    output logic              dtlb_gnt_o,
    output logic              dtlb_rsp_o,
    output logic [PTE_W-1:0]  rsp_pte_o,
    output logic              rsp_err_o,
    output logic              stlb_lookup_o,
    output logic [VPN_W-1:0]  stlb_vpn_o,
    output logic [ASID_W-1:0] stlb_asid_o,
    input  logic              stlb_hit_i,
    input  logic [PTE_W-1:0]  stlb_pte_i,
    output logic              stlb_fill_o,
    output logic              ptw_req_o,
    output logic              ptw_is_instr_o,
    output logic [VPN_W-1:0]  ptw_vpn_o,
    input  logic              ptw_done_i,
    input  logic              ptw_err_i,
`ifdef MMU_SCHED_PERF_EN
    input  logic [PTE_W-1:0]  ptw_pte_i,
    output logic [31:0]       perf_hit_cnt_o,
    output logic [31:0]       perf_walk_cnt_o
`else
    input  logic [PTE_W-1:0]  ptw_pte_i
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WALK,
        S_RESP,
        S_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic [VPN_W-1:0]  vpn_q, vpn_d;
    logic [ASID_W-1:0] asid_q, asid_d;
    logic              src_q, src_d;      // 1 = miss belongs to the ITLB
    logic [PTE_W-1:0]  pte_q, pte_d;
    logic              err_q, err_d;
    logic              pick_itlb;

    // ITLB wins when it is alone or when it has been passed over STARVE_MAX times
    assign pick_itlb = itlb_req_i && (!dtlb_req_i || (starve_q == 4'(STARVE_MAX)));

    // State register and miss context, cleared by synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            starve_q <= '0;
            vpn_q    <= '0;
            asid_q   <= '0;
            src_q    <= 1'b0;
            pte_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            vpn_q    <= vpn_d;
            asid_q   <= asid_d;
            src_q    <= src_d;
            pte_q    <= pte_d;
            err_q    <= err_d;
        end
    end

    // Next-state, arbitration and all outputs; grants are combinational in IDLE
    always_comb begin
        state_d        = state_q;
        starve_d       = starve_q;
        vpn_d          = vpn_q;
        asid_d         = asid_q;
        src_d          = src_q;
        pte_d          = pte_q;
        err_d          = err_q;
        itlb_gnt_o     = 1'b0;
        dtlb_gnt_o     = 1'b0;
        itlb_rsp_o     = 1'b0;
        dtlb_rsp_o     = 1'b0;
        rsp_pte_o      = '0;
        rsp_err_o      = 1'b0;
        stlb_lookup_o  = 1'b0;
        stlb_vpn_o     = '0;
        stlb_asid_o    = '0;
        stlb_fill_o    = 1'b0;
        ptw_req_o      = 1'b0;
        ptw_is_instr_o = 1'b0;
        ptw_vpn_o      = '0;

        case (state_q)
            S_IDLE: begin
                if (!rst_i && !flush_i && (itlb_req_i || dtlb_req_i)) begin
                    stlb_lookup_o = 1'b1;
                    stlb_asid_o   = asid_i;
                    asid_d        = asid_i;
                    src_d         = pick_itlb;
                    state_d       = S_LOOKUP;
                    if (pick_itlb) begin
                        itlb_gnt_o = 1'b1;
                        stlb_vpn_o = itlb_vpn_i;
                        vpn_d      = itlb_vpn_i;
                        starve_d   = '0;
                    end else begin
                        dtlb_gnt_o = 1'b1;
                        stlb_vpn_o = dtlb_vpn_i;
                        vpn_d      = dtlb_vpn_i;
                        if (itlb_req_i && (starve_q != 4'hF)) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                end
            end
            S_LOOKUP: begin
                stlb_vpn_o  = vpn_q;
                stlb_asid_o = asid_q;
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (stlb_hit_i) begin
                    pte_d   = stlb_pte_i;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    state_d = S_WALK;
                end
            end
            S_WALK: begin
                ptw_req_o      = 1'b1;
                ptw_is_instr_o = src_q;
                ptw_vpn_o      = vpn_q;
                stlb_vpn_o     = vpn_q;
                stlb_asid_o    = asid_q;
                if (flush_i) begin
                    state_d = ptw_done_i ? S_IDLE : S_DRAIN;
                end else if (ptw_done_i) begin
                    pte_d       = ptw_pte_i;
                    err_d       = ptw_err_i;
                    stlb_fill_o = !ptw_err_i;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                stlb_vpn_o  = vpn_q;
                stlb_asid_o = asid_q;
                if (!flush_i) begin
                    itlb_rsp_o = src_q;
                    dtlb_rsp_o = !src_q;
                    rsp_pte_o  = pte_q;
                    rsp_err_o  = err_q;
                end
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                stlb_vpn_o  = vpn_q;
                stlb_asid_o = asid_q;
                if (ptw_done_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef MMU_SCHED_PERF_EN
    logic [31:0] perf_hit_q, perf_walk_q;

    // Free-running hit and walk-entry counters; only reset clears them
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_hit_q  <= '0;
            perf_walk_q <= '0;
        end else begin
            if (state_q == S_LOOKUP && stlb_hit_i) begin
                perf_hit_q <= perf_hit_q + 32'd1;
            end
            if (state_q == S_LOOKUP && state_d == S_WALK) begin
                perf_walk_q <= perf_walk_q + 32'd1;
            end
        end
    end

    assign perf_hit_cnt_o  = perf_hit_q;
    assign perf_walk_cnt_o = perf_walk_q;
`endif

endmodule

// File: tb/tb_mmu_tlb_miss_sched.sv
// tb_mmu_tlb_miss_sched: directed self-checking bench for mmu_tlb_miss_sched.
// Define MMU_SCHED_PERF_EN for both files to exercise the performance counters.
module tb_mmu_tlb_miss_sched;

    localparam int VPN_W  = 27;
    localparam int ASID_W = 16;
    localparam int PTE_W  = 64;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic [ASID_W-1:0] asid_i;
    logic              itlb_req_i;
    logic [VPN_W-1:0]  itlb_vpn_i;
    logic              itlb_gnt_o;
    logic              itlb_rsp_o;
    logic              dtlb_req_i;
    logic [VPN_W-1:0]  dtlb_vpn_i;
    logic              dtlb_gnt_o;
    logic              dtlb_rsp_o;
    logic [PTE_W-1:0]  rsp_pte_o;
    logic              rsp_err_o;
    logic              stlb_lookup_o;
    logic [VPN_W-1:0]  stlb_vpn_o;
    logic [ASID_W-1:0] stlb_asid_o;
    logic              stlb_hit_i;
    logic [PTE_W-1:0]  stlb_pte_i;
    logic              stlb_fill_o;
    logic              ptw_req_o;
    logic              ptw_is_instr_o;
    logic [VPN_W-1:0]  ptw_vpn_o;
    logic              ptw_done_i;
    logic              ptw_err_i;
    logic [PTE_W-1:0]  ptw_pte_i;
`ifdef MMU_SCHED_PERF_EN
    logic [31:0]       perf_hit_cnt_o;
    logic [31:0]       perf_walk_cnt_o;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    mmu_tlb_miss_sched dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .asid_i         (asid_i),
        .itlb_req_i     (itlb_req_i),
        .itlb_vpn_i     (itlb_vpn_i),
        .itlb_gnt_o     (itlb_gnt_o),
        .itlb_rsp_o     (itlb_rsp_o),
        .dtlb_req_i     (dtlb_req_i),
        .dtlb_vpn_i     (dtlb_vpn_i),
        .dtlb_gnt_o     (dtlb_gnt_o),
        .dtlb_rsp_o     (dtlb_rsp_o),
        .rsp_pte_o      (rsp_pte_o),
        .rsp_err_o      (rsp_err_o),
        .stlb_lookup_o  (stlb_lookup_o),
        .stlb_vpn_o     (stlb_vpn_o),
        .stlb_asid_o    (stlb_asid_o),
        .stlb_hit_i     (stlb_hit_i),
        .stlb_pte_i     (stlb_pte_i),
        .stlb_fill_o    (stlb_fill_o),
        .ptw_req_o      (ptw_req_o),
        .ptw_is_instr_o (ptw_is_instr_o),
        .ptw_vpn_o      (ptw_vpn_o),
        .ptw_done_i     (ptw_done_i),
        .ptw_err_i      (ptw_err_i),
`ifdef MMU_SCHED_PERF_EN
        .ptw_pte_i      (ptw_pte_i),
        .perf_hit_cnt_o (perf_hit_cnt_o),
        .perf_walk_cnt_o(perf_walk_cnt_o)
`else
        .ptw_pte_i      (ptw_pte_i)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge; inputs are then changed and
    // outputs sampled a further #1 later, well away from either clock edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; asid_i = '0;
        itlb_req_i = 1'b0; itlb_vpn_i = '0; dtlb_req_i = 1'b0; dtlb_vpn_i = '0;
        stlb_hit_i = 1'b0; stlb_pte_i = '0;
        ptw_done_i = 1'b0; ptw_err_i = 1'b0; ptw_pte_i = '0;
        step();
        step();
        rst_i = 1'b0;
        #1;
        testsRun++;
        if ({itlb_gnt_o, itlb_rsp_o, dtlb_gnt_o, dtlb_rsp_o, rsp_err_o, stlb_lookup_o,
             stlb_fill_o, ptw_req_o, ptw_is_instr_o} !== 9'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_strobes: got %b expected 0",
                     {itlb_gnt_o, itlb_rsp_o, dtlb_gnt_o, dtlb_rsp_o, rsp_err_o,
                      stlb_lookup_o, stlb_fill_o, ptw_req_o, ptw_is_instr_o});
        end
        testsRun++;
        if ({rsp_pte_o, stlb_vpn_o, stlb_asid_o, ptw_vpn_o} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_buses: pte=%h svpn=%h asid=%h pvpn=%h expected 0",
                     rsp_pte_o, stlb_vpn_o, stlb_asid_o, ptw_vpn_o);
        end
`ifdef MMU_SCHED_PERF_EN
        testsRun++;
        if ({perf_hit_cnt_o, perf_walk_cnt_o} !== 64'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_perf: hit=%0d walk=%0d expected 0", perf_hit_cnt_o, perf_walk_cnt_o);
        end
`endif
    endtask

    task automatic test_dtlb_hit();
        // flush in IDLE blocks the grant
        flush_i = 1'b1; dtlb_req_i = 1'b1; dtlb_vpn_i = 27'h123; asid_i = 16'h0005;
        #1;
        testsRun++;
        if (dtlb_gnt_o !== 1'b0 || stlb_lookup_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL idle_flush_nogrant: gnt=%b lookup=%b expected 0 0", dtlb_gnt_o, stlb_lookup_o);
        end
        step();
        flush_i = 1'b0;
        #1;
        testsRun++;
        if (dtlb_gnt_o !== 1'b1 || itlb_gnt_o !== 1'b0 || stlb_lookup_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL hit_grant: dgnt=%b ignt=%b lookup=%b expected 1 0 1", dtlb_gnt_o, itlb_gnt_o, stlb_lookup_o);
        end
        testsRun++;
        if (stlb_vpn_o !== 27'h123 || stlb_asid_o !== 16'h0005) begin
            testsFailed++;
            $display("[TB] FAIL hit_lookup_addr: vpn=%h asid=%h expected 123 0005", stlb_vpn_o, stlb_asid_o);
        end
        step();
        dtlb_req_i = 1'b0; stlb_hit_i = 1'b1; stlb_pte_i = 64'hABC;
        #1;
        testsRun++;
        if (dtlb_rsp_o !== 1'b0 || ptw_req_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL hit_lookup_cycle: rsp=%b ptw=%b expected 0 0", dtlb_rsp_o, ptw_req_o);
        end
        step();
        stlb_hit_i = 1'b0; stlb_pte_i = '0;
        #1;
        testsRun++;
        if (dtlb_rsp_o !== 1'b1 || itlb_rsp_o !== 1'b0 || rsp_pte_o !== 64'hABC ||
            rsp_err_o !== 1'b0 || ptw_req_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL hit_rsp: drsp=%b irsp=%b pte=%h err=%b ptw=%b expected 1 0 abc 0 0",
                     dtlb_rsp_o, itlb_rsp_o, rsp_pte_o, rsp_err_o, ptw_req_o);
        end
        step();
        #1;
        testsRun++;
        if (dtlb_rsp_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL hit_rsp_one_cycle: rsp=%b expected 0", dtlb_rsp_o);
        end
    endtask

    task automatic test_itlb_miss();
        itlb_req_i = 1'b1; itlb_vpn_i = 27'h7; asid_i = 16'h0011;
        #1;
        testsRun++;
        if (itlb_gnt_o !== 1'b1 || stlb_vpn_o !== 27'h7) begin
            testsFailed++;
            $display("[TB] FAIL miss_grant: gnt=%b vpn=%h expected 1 7", itlb_gnt_o, stlb_vpn_o);
        end
        step();
        itlb_req_i = 1'b0; asid_i = 16'h0022;
        #1;
        testsRun++;
        if (ptw_req_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL miss_lookup_noptw: ptw=%b expected 0", ptw_req_o);
        end
        for (int c = 2; c <= 5; c++) begin
            step();
            #1;
            testsRun++;
            if (ptw_req_o !== 1'b1 || ptw_is_instr_o !== 1'b1 || ptw_vpn_o !== 27'h7 || stlb_fill_o !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL miss_walk_T%0d: req=%b instr=%b vpn=%h fill=%b expected 1 1 7 0",
                         c, ptw_req_o, ptw_is_instr_o, ptw_vpn_o, stlb_fill_o);
            end
        end
        step();
        ptw_done_i = 1'b1; ptw_pte_i = 64'h55; ptw_err_i = 1'b0;
        #1;
        testsRun++;
        if (ptw_req_o !== 1'b1 || stlb_fill_o !== 1'b1 || stlb_vpn_o !== 27'h7 || stlb_asid_o !== 16'h0011) begin
            testsFailed++;
            $display("[TB] FAIL miss_fill: req=%b fill=%b vpn=%h asid=%h expected 1 1 7 0011",
                     ptw_req_o, stlb_fill_o, stlb_vpn_o, stlb_asid_o);
        end
        step();
        ptw_done_i = 1'b0; ptw_pte_i = '0;
        #1;
        testsRun++;
        if (itlb_rsp_o !== 1'b1 || dtlb_rsp_o !== 1'b0 || rsp_pte_o !== 64'h55 ||
            rsp_err_o !== 1'b0 || ptw_req_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL miss_rsp: irsp=%b drsp=%b pte=%h err=%b ptw=%b expected 1 0 55 0 0",
                     itlb_rsp_o, dtlb_rsp_o, rsp_pte_o, rsp_err_o, ptw_req_o);
        end
        step();
    endtask

    task automatic test_starvation();
        logic [9:0] expI;
        expI = 10'b10_0001_0000;
        itlb_req_i = 1'b1; itlb_vpn_i = 27'h1000; dtlb_req_i = 1'b1; dtlb_vpn_i = 27'h2000;
        for (int k = 0; k < 10; k++) begin
            #1;
            testsRun++;
            if (itlb_gnt_o !== expI[k] || dtlb_gnt_o !== !expI[k]) begin
                testsFailed++;
                $display("[TB] FAIL starve_grant_%0d: ignt=%b dgnt=%b expected %b %b",
                         k, itlb_gnt_o, dtlb_gnt_o, expI[k], !expI[k]);
            end
            step();
            stlb_hit_i = 1'b1; stlb_pte_i = 64'(k + 16);
            step();
            stlb_hit_i = 1'b0; stlb_pte_i = '0;
            #1;
            testsRun++;
            if (itlb_rsp_o !== expI[k] || dtlb_rsp_o !== !expI[k] || rsp_pte_o !== 64'(k + 16)) begin
                testsFailed++;
                $display("[TB] FAIL starve_rsp_%0d: irsp=%b drsp=%b pte=%h expected %b %b %h",
                         k, itlb_rsp_o, dtlb_rsp_o, rsp_pte_o, expI[k], !expI[k], 64'(k + 16));
            end
            step();
        end
        itlb_req_i = 1'b0; dtlb_req_i = 1'b0;
        step();
    endtask

    task automatic test_walk_error();
        dtlb_req_i = 1'b1; dtlb_vpn_i = 27'h200;
        step();
        dtlb_req_i = 1'b0;
        step();
        #1;
        testsRun++;
        if (ptw_req_o !== 1'b1 || ptw_is_instr_o !== 1'b0 || stlb_fill_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL err_walk: req=%b instr=%b fill=%b expected 1 0 0", ptw_req_o, ptw_is_instr_o, stlb_fill_o);
        end
        step();
        ptw_done_i = 1'b1; ptw_err_i = 1'b1; ptw_pte_i = 64'hDEAD;
        #1;
        testsRun++;
        if (stlb_fill_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL err_nofill: fill=%b expected 0", stlb_fill_o);
        end
        step();
        ptw_done_i = 1'b0; ptw_err_i = 1'b0; ptw_pte_i = '0;
        #1;
        testsRun++;
        if (dtlb_rsp_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_pte_o !== 64'hDEAD || stlb_fill_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL err_rsp: rsp=%b err=%b pte=%h fill=%b expected 1 1 dead 0",
                     dtlb_rsp_o, rsp_err_o, rsp_pte_o, stlb_fill_o);
        end
        step();
    endtask

    task automatic test_flush_walk();
        dtlb_req_i = 1'b1; dtlb_vpn_i = 27'h300;
        step();
        dtlb_req_i = 1'b0;
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0; dtlb_req_i = 1'b1; dtlb_vpn_i = 27'h301;
        for (int c = 0; c < 2; c++) begin
            #1;
            testsRun++;
            if (ptw_req_o !== 1'b0 || dtlb_gnt_o !== 1'b0 || stlb_fill_o !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL drain_%0d: ptw=%b gnt=%b fill=%b expected 0 0 0", c, ptw_req_o, dtlb_gnt_o, stlb_fill_o);
            end
            step();
        end
        ptw_done_i = 1'b1; ptw_pte_i = 64'h77;
        #1;
        testsRun++;
        if (stlb_fill_o !== 1'b0 || dtlb_gnt_o !== 1'b0 || dtlb_rsp_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL drain_done: fill=%b gnt=%b rsp=%b expected 0 0 0", stlb_fill_o, dtlb_gnt_o, dtlb_rsp_o);
        end
        step();
        ptw_done_i = 1'b0; ptw_pte_i = '0;
        #1;
        testsRun++;
        if (dtlb_gnt_o !== 1'b1 || dtlb_rsp_o !== 1'b0 || stlb_vpn_o !== 27'h301) begin
            testsFailed++;
            $display("[TB] FAIL drain_regrant: gnt=%b rsp=%b vpn=%h expected 1 0 301", dtlb_gnt_o, dtlb_rsp_o, stlb_vpn_o);
        end
        step();
        dtlb_req_i = 1'b0; stlb_hit_i = 1'b1; stlb_pte_i = 64'h1;
        step();
        stlb_hit_i = 1'b0;
        step();
    endtask

    task automatic test_flush_lookup_resp();
        dtlb_req_i = 1'b1; dtlb_vpn_i = 27'h40;
        step();
        dtlb_req_i = 1'b0; flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        #1;
        testsRun++;
        if (ptw_req_o !== 1'b0 || dtlb_rsp_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL flush_lookup: ptw=%b rsp=%b expected 0 0", ptw_req_o, dtlb_rsp_o);
        end
        dtlb_req_i = 1'b1; dtlb_vpn_i = 27'h41;
        #1;
        testsRun++;
        if (dtlb_gnt_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL flush_lookup_idle: gnt=%b expected 1", dtlb_gnt_o);
        end
        step();
        dtlb_req_i = 1'b0; stlb_hit_i = 1'b1; stlb_pte_i = 64'h99;
        step();
        stlb_hit_i = 1'b0; flush_i = 1'b1;
        #1;
        testsRun++;
        if (dtlb_rsp_o !== 1'b0 || itlb_rsp_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL flush_resp: drsp=%b irsp=%b expected 0 0", dtlb_rsp_o, itlb_rsp_o);
        end
        step();
        flush_i = 1'b0; itlb_req_i = 1'b1; itlb_vpn_i = 27'h42;
        #1;
        testsRun++;
        if (itlb_gnt_o !== 1'b1 || dtlb_rsp_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL flush_resp_idle: gnt=%b drsp=%b expected 1 0", itlb_gnt_o, dtlb_rsp_o);
        end
        step();
        itlb_req_i = 1'b0; stlb_hit_i = 1'b1;
        step();
        stlb_hit_i = 1'b0;
        step();
    endtask

    task automatic test_reset_walk();
        itlb_req_i = 1'b1; itlb_vpn_i = 27'h9;
        step();
        itlb_req_i = 1'b0;
        step();
        #1;
        testsRun++;
        if (ptw_req_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rstwalk_inwalk: ptw=%b expected 1", ptw_req_o);
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0; ptw_done_i = 1'b1; ptw_pte_i = 64'h66;
        #1;
        testsRun++;
        if ({itlb_gnt_o, itlb_rsp_o, dtlb_gnt_o, dtlb_rsp_o, rsp_err_o, stlb_lookup_o,
             stlb_fill_o, ptw_req_o, ptw_is_instr_o} !== 9'b0 ||
            {rsp_pte_o, stlb_vpn_o, ptw_vpn_o} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL rstwalk_outputs: ptw=%b fill=%b instr=%b svpn=%h pvpn=%h expected all 0",
                     ptw_req_o, stlb_fill_o, ptw_is_instr_o, stlb_vpn_o, ptw_vpn_o);
        end
`ifdef MMU_SCHED_PERF_EN
        testsRun++;
        if ({perf_hit_cnt_o, perf_walk_cnt_o} !== 64'd0) begin
            testsFailed++;
            $display("[TB] FAIL rstwalk_perf: hit=%0d walk=%0d expected 0", perf_hit_cnt_o, perf_walk_cnt_o);
        end
`endif
        step();
        ptw_done_i = 1'b0; ptw_pte_i = '0;
        #1;
        testsRun++;
        if (itlb_rsp_o !== 1'b0 || stlb_fill_o !== 1'b0 || ptw_req_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rstwalk_late_done: rsp=%b fill=%b ptw=%b expected 0 0 0", itlb_rsp_o, stlb_fill_o, ptw_req_o);
        end
        dtlb_req_i = 1'b1; dtlb_vpn_i = 27'h50;
        #1;
        testsRun++;
        if (dtlb_gnt_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rstwalk_regrant: gnt=%b expected 1", dtlb_gnt_o);
        end
        step();
        dtlb_req_i = 1'b0; stlb_hit_i = 1'b1; stlb_pte_i = 64'h3;
        step();
        stlb_hit_i = 1'b0;
        step();
`ifdef MMU_SCHED_PERF_EN
        testsRun++;
        if (perf_hit_cnt_o !== 32'd1 || perf_walk_cnt_o !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL perf_after_hit: hit=%0d walk=%0d expected 1 0", perf_hit_cnt_o, perf_walk_cnt_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_dtlb_hit();
        test_itlb_miss();
        test_starvation();
        test_walk_error();
        test_flush_walk();
        test_flush_lookup_resp();
        test_reset_walk();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
